// File: rtl/blink_key_loader.sv
// Round-key staging buffer for the Blink-128 core.
// Define BLINK_KEY_SHADOW_EN for shadow bank + atomic commit.
module blink_key_loader #(
  parameter int N     = 128,
  parameter int WORDS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 kin_valid,
  input  logic [N-1:0]         kin_data,
  input  logic                 kin_last,
  output logic                 kin_ready,
  input  logic                 hold,
  output logic [N*WORDS-1:0]   K0,
  output logic                 key_valid,
  output logic                 err_len
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  logic [CW-1:0] cnt;
  logic          xfer;
  logic          at_last;
  logic          done;
  logic          abort;

  assign xfer    = kin_valid & kin_ready;
  assign at_last = (cnt == LAST);
  assign done    = xfer & at_last & kin_last;
  assign abort   = xfer & (at_last ^ kin_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      err_len <= 1'b0;
    end else begin
      err_len <= abort;
      if (xfer)
        cnt <= (at_last | kin_last) ? '0 : cnt + 1'b1;
    end
  end

`ifdef BLINK_KEY_SHADOW_EN

  typedef enum logic {
    S_LOAD,
    S_COMMIT
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic               commit;
  logic [N*WORDS-1:0] shadow;
  logic [N*WORDS-1:0] staged;

  // staged = shadow bank with the current word merged in
  always_comb begin
    staged = shadow;
    staged[int'(cnt)*N +: N] = kin_data;
    state_nx = state;
    commit   = 1'b0;
    unique case (state)
      S_LOAD: begin
        if (done) begin
          if (hold) state_nx = S_COMMIT;
          else      commit   = 1'b1;
        end
      end
      S_COMMIT: begin
        if (!hold) begin
          commit   = 1'b1;
          state_nx = S_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      kin_ready <= 1'b1;
      shadow    <= '0;
      K0        <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      kin_ready <= (state_nx == S_LOAD);
      if (xfer)
        shadow <= staged;
      if (commit) begin
        K0        <= (state == S_LOAD) ? staged : shadow;
        key_valid <= 1'b1;
      end
    end
  end

`else

  assign kin_ready = !hold;

  // words land straight in K0; key_valid tracks set completeness
  always_ff @(posedge clk) begin
    if (rst) begin
      K0        <= '0;
      key_valid <= 1'b0;
    end else if (xfer) begin
      K0[int'(cnt)*N +: N] <= kin_data;
      if (cnt == '0)
        key_valid <= 1'b0;
      if (done)
        key_valid <= 1'b1;
      else if (abort)
        key_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_blink_key_loader.sv
// Directed bench for blink_key_loader.
// Expectations follow BLINK_KEY_SHADOW_EN when defined.
module tb_blink_key_loader;
  localparam int N     = 128;
  localparam int WORDS = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               kin_valid;
  logic [N-1:0]       kin_data;
  logic               kin_last;
  logic               kin_ready;
  logic               hold;
  logic [N*WORDS-1:0] K0;
  logic               key_valid;
  logic               err_len;

  int checks = 0;
  int errors = 0;

  localparam logic [N-1:0] A5 = {16{8'hA5}};

  always #5 clk = ~clk;

  blink_key_loader #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk),
    .rst(rst),
    .kin_valid(kin_valid),
    .kin_data(kin_data),
    .kin_last(kin_last),
    .kin_ready(kin_ready),
    .hold(hold),
    .K0(K0),
    .key_valid(key_valid),
    .err_len(err_len)
  );

  function automatic logic [N*WORDS-1:0] set_of(input logic [N-1:0] base);
    logic [N*WORDS-1:0] r;
    for (int i = 0; i < WORDS; i++)
      r[i*N +: N] = base + N'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] d, input logic last);
    kin_valid = 1'b1;
    kin_data  = d;
    kin_last  = last;
    tick();
    kin_valid = 1'b0;
    kin_last  = 1'b0;
    kin_data  = '0;
  endtask

  task automatic load(input logic [N-1:0] base, input int n,
                      input int last_at);
    for (int i = 0; i < n; i++)
      send(base + N'(i), i == last_at);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (K0 !== '0) begin
      errors++;
      $display("FAIL reset_k0: got %h want 0", K0);
    end
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_key_valid: got %b want 0", key_valid);
    end
    checks++;
    if (err_len !== 1'b0) begin
      errors++;
      $display("FAIL reset_err_len: got %b want 0", err_len);
    end
    checks++;
    if (kin_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_kin_ready: got %b want 1", kin_ready);
    end
  endtask

  task automatic test_basic();
    logic [N*WORDS-1:0] exp;
    exp = set_of('0);
    load('0, 7, -1);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: got %b want 0", key_valid);
    end
    send(N'(7), 1'b1);
    checks++;
    if (key_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_key_valid: got %b want 1", key_valid);
    end
    checks++;
    if (K0[127:0] !== 128'd0 || K0[1023:896] !== 128'd7) begin
      errors++;
      $display("FAIL basic_ends: got %h/%h want 0/7",
               K0[127:0], K0[1023:896]);
    end
    checks++;
    if (K0 !== exp) begin
      errors++;
      $display("FAIL basic_k0: got %h want %h", K0, exp);
    end
  endtask

  task automatic test_early_last();
    logic [N*WORDS-1:0] exp;
    logic [N*WORDS-1:0] nw;
    logic               exp_kv;
    exp = set_of('0);
`ifdef BLINK_KEY_SHADOW_EN
    exp_kv = 1'b1;
`else
    nw  = set_of(N'(100));
    exp[4*N-1:0] = nw[4*N-1:0];
    exp_kv = 1'b0;
`endif
    load(N'(100), 4, 3);
    checks++;
    if (err_len !== 1'b1) begin
      errors++;
      $display("FAIL early_err_len: got %b want 1", err_len);
    end
    checks++;
    if (K0 !== exp) begin
      errors++;
      $display("FAIL early_k0: got %h want %h", K0, exp);
    end
    checks++;
    if (key_valid !== exp_kv) begin
      errors++;
      $display("FAIL early_key_valid: got %b want %b", key_valid, exp_kv);
    end
    tick();
    checks++;
    if (err_len !== 1'b0) begin
      errors++;
      $display("FAIL early_err_pulse: got %b want 0", err_len);
    end
    load(N'(200), 8, 7);
    exp = set_of(N'(200));
    checks++;
    if (K0 !== exp || key_valid !== 1'b1) begin
      errors++;
      $display("FAIL early_reload: got %h/%b want %h/1",
               K0, key_valid, exp);
    end
  endtask

  task automatic test_missing_last();
    logic [N*WORDS-1:0] exp;
    logic               exp_kv;
`ifdef BLINK_KEY_SHADOW_EN
    exp    = set_of(N'(200));
    exp_kv = 1'b1;
`else
    exp    = set_of(N'(300));
    exp_kv = 1'b0;
`endif
    load(N'(300), 8, -1);
    checks++;
    if (err_len !== 1'b1) begin
      errors++;
      $display("FAIL missing_err_len: got %b want 1", err_len);
    end
    checks++;
    if (K0 !== exp || key_valid !== exp_kv) begin
      errors++;
      $display("FAIL missing_k0: got %h/%b want %h/%b",
               K0, key_valid, exp, exp_kv);
    end
    tick();
    checks++;
    if (err_len !== 1'b0) begin
      errors++;
      $display("FAIL missing_err_pulse: got %b want 0", err_len);
    end
  endtask

  task automatic test_hold();
    logic [N*WORDS-1:0] old;
    logic [N*WORDS-1:0] nw;
    old = set_of(N'(700));
    nw  = set_of(A5);
    load(N'(700), 8, 7);
    checks++;
    if (K0 !== old || key_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_preload: got %h/%b want %h/1",
               K0, key_valid, old);
    end
    hold = 1'b1;
`ifdef BLINK_KEY_SHADOW_EN
    load(A5, 7, -1);
    checks++;
    if (kin_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_load_ready: got %b want 1", kin_ready);
    end
    send(A5 + N'(7), 1'b1);
    checks++;
    if (kin_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_ready_low: got %b want 0", kin_ready);
    end
`else
    #1;
    checks++;
    if (kin_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_ready_low: got %b want 0", kin_ready);
    end
`endif
    for (int c = 0; c < 10; c++) begin
      kin_valid = 1'b1;
      kin_data  = '1;
      kin_last  = 1'b1;
      tick();
      checks++;
      if (K0 !== old || key_valid !== 1'b1 || kin_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got %h/%b/%b want %h/1/0",
                 c, K0, key_valid, kin_ready, old);
      end
    end
    kin_valid = 1'b0;
    kin_last  = 1'b0;
    kin_data  = '0;
    hold      = 1'b0;
`ifdef BLINK_KEY_SHADOW_EN
    tick();
    checks++;
    if (K0 !== nw || key_valid !== 1'b1 || kin_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got %h/%b/%b want %h/1/1",
               K0, key_valid, kin_ready, nw);
    end
    checks++;
    if (err_len !== 1'b0) begin
      errors++;
      $display("FAIL hold_ignored: got err_len %b want 0", err_len);
    end
`else
    #1;
    checks++;
    if (kin_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release_ready: got %b want 1", kin_ready);
    end
    send(A5, 1'b0);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_word0_valid: got %b want 0", key_valid);
    end
    for (int i = 1; i < WORDS; i++)
      send(A5 + N'(i), i == WORDS - 1);
    checks++;
    if (K0 !== nw || key_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got %h/%b want %h/1",
               K0, key_valid, nw);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [N*WORDS-1:0] exp;
    exp = set_of(N'(800));
    load(N'(800), 8, 7);
    checks++;
    if (K0 !== exp || key_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got %h/%b want %h/1", K0, key_valid, exp);
    end
    exp = set_of(N'(900));
    load(N'(900), 8, 7);
    checks++;
    if (K0 !== exp || key_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got %h/%b want %h/1", K0, key_valid, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [N*WORDS-1:0] exp;
    exp = set_of(N'(600));
    load(N'(500), 5, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (K0 !== '0 || key_valid !== 1'b0 || kin_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_clear: got %h/%b/%b want 0/0/1",
               K0, key_valid, kin_ready);
    end
    load(N'(600), 7, -1);
    checks++;
    if (key_valid !== 1'b0 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_seven: got %b/%b want 0/0", key_valid, err_len);
    end
    send(N'(607), 1'b1);
    checks++;
    if (K0 !== exp || key_valid !== 1'b1 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_commit: got %h/%b/%b want %h/1/0",
               K0, key_valid, err_len, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    kin_valid = 1'b0;
    kin_data  = '0;
    kin_last  = 1'b0;
    hold      = 1'b0;
    test_reset();
    test_basic();
    test_early_last();
    test_missing_last();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
